yv_row_mac: RTL and testbench
=============================

Name: yv_row_mac

Overview:
- Consumer stage directly downstream of the Y/V address-control block.
- Each cycle takes up to two paired operands (Y value, V value fetched via the sel_v1_v3 / sel_v2_v4 muxed SRAM reads) and multiply-accumulates them per matrix row.
- On the row-close flag it pushes {row index, sum, overflow} into a small output FIFO for the writeback stage.
- Provides valid/ready backpressure toward the control block.

Parameters:
- DATA_W, 16, signed width of each Y and V operand.
- ACC_W, 40, signed accumulator / result width.
- ROW_W, 11, row index width (matches Y_addressline width).
- ROW_BASE, 63, row index assigned to the first row after reset/start.
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- start  in  1  sync pulse: clear accumulator, drop stage-1 beat, reload row index to ROW_BASE; FIFO contents kept.
- in_valid  in  1  input beat present.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- lane_a_vld  in  1  lane A operands meaningful (low for new-row marker / ram_no 3'b100).
- y_a  in  DATA_W  lane A Y value, signed.
- v_a  in  DATA_W  lane A V value, signed.
- lane_b_vld  in  1  lane B operands meaningful.
- y_b  in  DATA_W  lane B Y value, signed.
- v_b  in  DATA_W  lane B V value, signed.
- row_last  in  1  this beat closes the current row.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream pops head when out_valid && out_ready.
- out_row  out  ROW_W  row index of head result.
- out_sum  out  ACC_W  signed row sum.
- out_ovf  out  1  signed overflow occurred at any add in that row.

Behaviour:
- Reset (async, low): in_ready=1 after release, out_valid=0, out_row=0, out_sum=0, out_ovf=0; acc=0, row index=ROW_BASE, FIFO empty, stage-1 empty.
- Stage 1, registered at the accepting edge:
  - prod_a = y_a*v_a (signed, 2*DATA_W), forced 0 if !lane_a_vld; same for prod_b.
  - row_last and beat-valid are registered alongside.
- Stage 2, next edge, if stage-1 valid:
  - sum = acc + sext(prod_a) + sext(prod_b), wrap modulo 2^ACC_W.
  - ovf_row |= signed overflow of either add.
  - If last: push {row_idx, sum, ovf_row} to the FIFO; acc<=0, ovf_row<=0, row_idx<=row_idx+1 (wraps 2^ROW_W-1 -> 0).
  - Else: acc<=sum.
- Latency: with FIFO empty, out_valid rises 2 edges after the edge accepting a row_last beat. Throughput is 1 beat/cycle.
- in_ready = (fifo_count + stage1_last) < FIFO_DEPTH, combinational from registers only. It never depends on in_valid or out_ready, so it never overflows the FIFO.
- Output FIFO:
  - First-word-fall-through; out_* are driven from the head entry.
  - out_* hold stable while out_valid && !out_ready.
  - Push and pop in the same cycle are allowed at any count, including full; count stays the same.
  - Pop when empty is ignored.
- row_last with both lanes invalid and no prior beats in the row: pushes sum 0, ovf 0 (empty row).
- start has priority over a same-cycle accepted beat: the beat is dropped, and in_ready is still asserted that cycle.
- Any stage-2 push already committed before start stays in the FIFO.
- Reset low mid-row or mid-FIFO: everything discarded immediately, with no partial push.
- in_valid with in_ready low: no state change; the source must hold the beat.

Test Plan:
- Reset, then 3 beats of row 63 with A=(2,3)/B=(4,5), (−1,7)/B invalid, (10,10)/B=(1,1) last -> out_row=63, out_sum=6+20−7+100+1=120, out_ovf=0, out_valid 2 edges after the last accept.
- Single beat, both lanes invalid, row_last -> out_sum=0 for row 63; the next row reports 64.
- out_ready held 0, stream 6 single-beat rows -> in_ready drops once 4 results are committed/in flight, no loss. Release out_ready -> rows 63..68 in order, sums intact.
- DATA_W=16, ACC_W=32, repeat (32767*32767) 3 beats in one row -> out_ovf=1, out_sum=wrapped value; the next row has ovf=0.
- Mid-row start, then a 1-beat row (3,3) last -> out_row=63, out_sum=9; the pre-start partial sum is absent.
- Row index preset near 2047 via 1985 rows -> row after 2047 reports 0. Async reset asserted mid-stream -> out_valid=0 immediately, FIFO empty.

Source files
------------

// File: rtl/yv_row_mac.sv
// yv_row_mac: per-row multiply-accumulate stage that sits behind the Y/V
// address-control block. Each beat carries up to two (Y, V) operand pairs;
// products are summed into a row accumulator, and the row-close flag
// pushes {row index, sum, overflow} into a small first-word-fall-through
// result FIFO for the writeback stage.
module yv_row_mac #(
    parameter int DATA_W     = 16,
    parameter int ACC_W      = 40,
    parameter int ROW_W      = 11,
    parameter int ROW_BASE   = 63,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              lane_a_vld,
    input  logic [DATA_W-1:0] y_a,
    input  logic [DATA_W-1:0] v_a,
    input  logic              lane_b_vld,
    input  logic [DATA_W-1:0] y_b,
    input  logic [DATA_W-1:0] v_b,
    input  logic              row_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROW_W-1:0]  out_row,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;

    // Stage-1 registers
    logic                     r_s1Vld;
    logic                     r_s1Last;
    logic signed [PROD_W-1:0] r_prodA;
    logic signed [PROD_W-1:0] r_prodB;

    // Row accumulation state
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_ovfRow;
    logic [ROW_W-1:0]         r_rowIdx;

    // Result FIFO
    logic [ROW_W-1:0]         r_fifoRow [FIFO_DEPTH];
    logic [ACC_W-1:0]         r_fifoSum [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]    r_fifoOvf;
    logic [PTR_W-1:0]         r_wrPtr;
    logic [PTR_W-1:0]         r_rdPtr;
    logic [CNT_W-1:0]         r_count;
    logic                     r_outValid;

    // Combinational helpers
    logic signed [PROD_W-1:0] w_yA, w_vA, w_yB, w_vB;
    logic signed [PROD_W-1:0] w_prodA, w_prodB;
    logic signed [ACC_W-1:0]  w_extA, w_extB, w_add1, w_sum;
    logic                     w_ovf1, w_ovf2, w_ovfRowNext;
    logic                     w_accept, w_push, w_pop;
    logic [CNT_W-1:0]         w_occupancy;

    // Operands are sign-extended to the full product width so the multiply
    // result is the exact signed product.
    assign w_yA    = PROD_W'($signed(y_a));
    assign w_vA    = PROD_W'($signed(v_a));
    assign w_yB    = PROD_W'($signed(y_b));
    assign w_vB    = PROD_W'($signed(v_b));
    assign w_prodA = lane_a_vld ? (w_yA * w_vA) : '0;
    assign w_prodB = lane_b_vld ? (w_yB * w_vB) : '0;

    // start wins over a beat offered in the same cycle; the beat is dropped.
    assign w_accept = in_valid && in_ready && !start;

    // A row-closing beat sitting in stage 1 has a FIFO slot reserved for it,
    // so in_ready only looks at registered state and can never overfill.
    assign w_occupancy = r_count + CNT_W'(r_s1Last);
    assign in_ready    = (w_occupancy < CNT_W'(FIFO_DEPTH));

    // Two chained wrapping adds, each checked for signed overflow.
    assign w_extA = ACC_W'(r_prodA);
    assign w_extB = ACC_W'(r_prodB);
    assign w_add1 = r_acc + w_extA;
    assign w_sum  = w_add1 + w_extB;
    assign w_ovf1 = (r_acc[ACC_W-1] == w_extA[ACC_W-1]) && (w_add1[ACC_W-1] != r_acc[ACC_W-1]);
    assign w_ovf2 = (w_add1[ACC_W-1] == w_extB[ACC_W-1]) && (w_sum[ACC_W-1] != w_add1[ACC_W-1]);
    assign w_ovfRowNext = r_ovfRow | w_ovf1 | w_ovf2;

    assign w_push = r_s1Vld && r_s1Last && !start;
    assign w_pop  = r_outValid && out_ready;

    assign out_valid = r_outValid;
    assign out_row   = r_fifoRow[r_rdPtr];
    assign out_sum   = r_fifoSum[r_rdPtr];
    assign out_ovf   = r_fifoOvf[r_rdPtr];

    // Stage 1: capture lane products and the row-close flag of an accepted beat.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1Vld  <= 1'b0;
            r_s1Last <= 1'b0;
            r_prodA  <= '0;
            r_prodB  <= '0;
        end else begin
            r_s1Vld  <= w_accept;
            r_s1Last <= w_accept && row_last;
            if (w_accept) begin
                r_prodA <= w_prodA;
                r_prodB <= w_prodB;
            end
        end
    end

    // Stage 2: accumulate into the current row, or close it and advance the row index.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_acc    <= '0;
            r_ovfRow <= 1'b0;
            r_rowIdx <= ROW_W'(ROW_BASE);
        end else if (start) begin
            r_acc    <= '0;
            r_ovfRow <= 1'b0;
            r_rowIdx <= ROW_W'(ROW_BASE);
        end else if (r_s1Vld) begin
            if (r_s1Last) begin
                r_acc    <= '0;
                r_ovfRow <= 1'b0;
                r_rowIdx <= r_rowIdx + ROW_W'(1);
            end else begin
                r_acc    <= w_sum;
                r_ovfRow <= w_ovfRowNext;
            end
        end
    end

    // Result FIFO: a freshly written entry is exposed one edge after its
    // write, while pops take effect immediately; start leaves contents alone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifoRow[i] <= '0;
                r_fifoSum[i] <= '0;
            end
            r_fifoOvf  <= '0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_outValid <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifoRow[r_wrPtr] <= r_rowIdx;
                r_fifoSum[r_wrPtr] <= w_sum;
                r_fifoOvf[r_wrPtr] <= w_ovfRowNext;
                r_wrPtr            <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            r_outValid <= ((r_count - CNT_W'(w_pop)) != '0);
        end
    end

endmodule

// File: tb/tb_yv_row_mac.sv
// tb_yv_row_mac: directed self-checking bench for yv_row_mac, built with a
// 32-bit accumulator so signed overflow is reachable with 16-bit operands.
module tb_yv_row_mac;

    localparam int DATA_W     = 16;
    localparam int ACC_W      = 32;
    localparam int ROW_W      = 11;
    localparam int ROW_BASE   = 63;
    localparam int FIFO_DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              lane_a_vld;
    logic [DATA_W-1:0] y_a, v_a;
    logic              lane_b_vld;
    logic [DATA_W-1:0] y_b, v_b;
    logic              row_last;
    logic              out_valid;
    logic              out_ready;
    logic [ROW_W-1:0]  out_row;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    int vectorsApplied = 0;
    int miscompares    = 0;
    int drainGot       = 0;

    yv_row_mac #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .ROW_W(ROW_W),
        .ROW_BASE(ROW_BASE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .lane_a_vld(lane_a_vld), .y_a(y_a), .v_a(v_a),
        .lane_b_vld(lane_b_vld), .y_b(y_b), .v_b(v_b),
        .row_last(row_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_sum(out_sum), .out_ovf(out_ovf)
    );

    // Free-running clock, 10 ns period
    always #5 clock = ~clock;

    // Single comparison point: count it and report any mismatch
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one beat at a negedge and hold it until accepted (bounded)
    task automatic applyStimulus(input logic aVld, input int ya, input int va,
                                 input logic bVld, input int yb, input int vb,
                                 input logic last);
        int waited;
        lane_a_vld = aVld; y_a = 16'(ya); v_a = 16'(va);
        lane_b_vld = bVld; y_b = 16'(yb); v_b = 16'(vb);
        row_last   = last;
        in_valid   = 1'b1;
        waited     = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            @(negedge clock);
        end
        in_valid = 1'b0;
        row_last = 1'b0;
    endtask

    // Head-of-FIFO expectation
    task automatic expectHead(input string tag, input int row, input logic [ACC_W-1:0] sum, input logic ovf);
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_row"},   64'(out_row),   64'(row));
        checkOutput({tag, "_sum"},   64'(out_sum),   64'(sum));
        checkOutput({tag, "_ovf"},   64'(out_ovf),   64'(ovf));
    endtask

    // Pop exactly one head entry
    task automatic popOne();
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    // One-cycle start pulse
    task automatic startPulse();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Hard time bound so the run can never hang
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence
    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        lane_a_vld = 1'b0; lane_b_vld = 1'b0; row_last = 1'b0;
        y_a = '0; v_a = '0; y_b = '0; v_b = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_row",   64'(out_row),   64'd0);
        checkOutput("rst_out_sum",   64'(out_sum),   64'd0);
        checkOutput("rst_out_ovf",   64'(out_ovf),   64'd0);

        // Three-beat row: 6+20 -7 +100+1 = 120
        applyStimulus(1, 2, 3, 1, 4, 5, 0);
        applyStimulus(1, -1, 7, 0, 0, 0, 0);
        applyStimulus(1, 10, 10, 1, 1, 1, 1);
        checkOutput("lat_edge0", 64'(out_valid), 64'd0);
        @(negedge clock);
        checkOutput("lat_edge1", 64'(out_valid), 64'd0);
        @(negedge clock);
        expectHead("row3beat", 63, 32'd120, 1'b0);
        popOne();
        checkOutput("row3beat_popped", 64'(out_valid), 64'd0);

        // Empty row, then the following row index
        startPulse();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(negedge clock);
        expectHead("empty_row", 63, 32'd0, 1'b0);
        popOne();
        applyStimulus(1, 1, 1, 0, 0, 0, 1);
        repeat (2) @(negedge clock);
        expectHead("after_empty", 64, 32'd1, 1'b0);
        popOne();

        // Backpressure: four single-beat rows fill the FIFO budget
        startPulse();
        for (int k = 0; k < 4; k++) applyStimulus(1, k + 1, 2, 0, 0, 0, 1);
        checkOutput("bp_ready_low", 64'(in_ready), 64'd0);
        repeat (3) @(negedge clock);
        checkOutput("bp_ready_hold", 64'(in_ready), 64'd0);
        drainGot = 0;
        fork
            begin
                applyStimulus(1, 5, 2, 0, 0, 0, 1);
                applyStimulus(1, 6, 2, 0, 0, 0, 1);
            end
            begin
                out_ready = 1'b1;
                for (int c = 0; c < 60 && drainGot < 6; c++) begin
                    if (out_valid) begin
                        checkOutput("bp_row", 64'(out_row), 64'(63 + drainGot));
                        checkOutput("bp_sum", 64'(out_sum), 64'(2 * drainGot + 2));
                        drainGot++;
                    end
                    @(negedge clock);
                end
                out_ready = 1'b0;
            end
        join
        checkOutput("bp_drain_count", 64'(drainGot), 64'd6);

        // Overflow: 3 * 32767^2 exceeds a signed 32-bit accumulator
        startPulse();
        applyStimulus(1, 32767, 32767, 0, 0, 0, 0);
        applyStimulus(1, 32767, 32767, 0, 0, 0, 0);
        applyStimulus(1, 32767, 32767, 0, 0, 0, 1);
        repeat (2) @(negedge clock);
        expectHead("ovf_row", 63, 32'hBFFD0003, 1'b1);
        popOne();
        applyStimulus(1, 1, 1, 0, 0, 0, 1);
        repeat (2) @(negedge clock);
        expectHead("ovf_next", 64, 32'd1, 1'b0);
        popOne();

        // Mid-row start: committed result kept, partial sum and same-cycle beat dropped
        startPulse();
        applyStimulus(1, 2, 2, 0, 0, 0, 1);
        repeat (2) @(negedge clock);
        expectHead("pre_start", 63, 32'd4, 1'b0);
        applyStimulus(1, 5, 5, 0, 0, 0, 0);
        applyStimulus(1, 7, 7, 0, 0, 0, 0);
        lane_a_vld = 1'b1; y_a = 16'd100; v_a = 16'd100; lane_b_vld = 1'b0;
        row_last = 1'b0; in_valid = 1'b1; start = 1'b1;
        checkOutput("start_ready", 64'(in_ready), 64'd1);
        @(negedge clock);
        start = 1'b0; in_valid = 1'b0;
        applyStimulus(1, 3, 3, 0, 0, 0, 1);
        repeat (2) @(negedge clock);
        expectHead("kept_over_start", 63, 32'd4, 1'b0);
        popOne();
        expectHead("post_start", 63, 32'd9, 1'b0);
        popOne();

        // Row index wrap: 1984 empty rows cover 63..2046
        startPulse();
        out_ready = 1'b1;
        for (int k = 0; k < 1984; k++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
        repeat (4) @(negedge clock);
        out_ready = 1'b0;
        checkOutput("bulk_drained", 64'(out_valid), 64'd0);
        applyStimulus(1, 2, 3, 0, 0, 0, 1);
        repeat (2) @(negedge clock);
        expectHead("row_2047", 2047, 32'd6, 1'b0);
        popOne();
        applyStimulus(1, 4, 4, 0, 0, 0, 1);
        repeat (2) @(negedge clock);
        expectHead("row_wrap", 0, 32'd16, 1'b0);
        popOne();

        // Async reset mid-stream discards FIFO contents and the partial row
        startPulse();
        applyStimulus(1, 1, 1, 0, 0, 0, 1);
        applyStimulus(1, 2, 2, 0, 0, 0, 1);
        repeat (2) @(negedge clock);
        checkOutput("prereset_valid", 64'(out_valid), 64'd1);
        applyStimulus(1, 5, 5, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("arst_out_sum",   64'(out_sum),   64'd0);
        checkOutput("arst_out_row",   64'(out_row),   64'd0);
        @(negedge clock);
        reset = 1'b1;
        checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(negedge clock);
        checkOutput("arst_no_push", 64'(out_valid), 64'd0);
        applyStimulus(1, 3, 3, 0, 0, 0, 1);
        repeat (2) @(negedge clock);
        expectHead("after_arst", 63, 32'd9, 1'b0);
        popOne();

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
